// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
//   mode_e  : 3-bit operation select, as driven on the usr_param mode input.
//   state_e : multi-step handshake FSM states.
package usr_pkg;

    typedef enum logic [2:0] {
        ModeHold = 3'd0,
        ModeShr  = 3'd1,
        ModeShl  = 3'd2,
        ModeLoad = 3'd3,
        ModeRor  = 3'd4,
        ModeRol  = 3'd5,
        ModeAsr  = 3'd6,
        ModeRsvd = 3'd7
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/usr_step.sv
// Combinational next-value function of the universal shift register.
// Configuration macro: USR_ROTATE_EN. When it is undefined, ROR and ROL decode as HOLD.
// Ports:
//   q      : current register contents
//   op     : operation to apply
//   d      : parallel load data
//   sil    : serial input entering the LSB on SHL
//   sir    : serial input entering the MSB on SHR
//   next_q : register value after one step of op
module usr_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            op,
    input  logic [WIDTH-1:0] d,
    input  logic             sil,
    input  logic             sir,
    output logic [WIDTH-1:0] next_q
);

    always_comb begin
        next_q = q;
        case (op)
            ModeShr:  next_q = {sir, q[WIDTH-1:1]};
            ModeShl:  next_q = {q[WIDTH-2:0], sil};
            ModeLoad: next_q = d;
`ifdef USR_ROTATE_EN
            ModeRor:  next_q = {q[0], q[WIDTH-1:1]};
            ModeRol:  next_q = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
            ModeAsr:  next_q = {q[WIDTH-1], q[WIDTH-1:1]};
            default:  next_q = q;
        endcase
    end

endmodule

// File: rtl/usr_param.sv
// Parametrised universal shift register with single-step and multi-step ("apply mode amt
// times") operation behind a start/busy/done handshake.
// Configuration macro: USR_ROTATE_EN (enables ROR/ROL; otherwise they act as HOLD).
// Ports:
//   clk   : rising-edge clock
//   clear : asynchronous active-low reset
//   en    : single-step enable (IDLE only)
//   mode  : operation select (see usr_pkg::mode_e)
//   d     : parallel load data, sampled live at every step
//   sir   : serial input into the MSB on SHR
//   sil   : serial input into the LSB on SHL
//   start : begin a multi-step operation (wins over en)
//   amt   : step count for a multi-step operation, 0..WIDTH
//   q     : register contents
//   so_r  : q[0]
//   so_l  : q[WIDTH-1]
//   busy  : multi-step operation in progress
//   done  : one-cycle completion pulse
module usr_param
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sir,
    input  logic             sil,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    state_e           state_r, state_d;
    logic [WIDTH-1:0] q_r, q_d;
    mode_e            op_r, op_d;
    logic [AMT_W-1:0] rem_r, rem_d;
    mode_e            step_op;
    logic [WIDTH-1:0] next_q;

    // In RUN the latched op is applied; in IDLE the live mode drives single steps.
    assign step_op = (state_r == StRun) ? op_r : mode_e'(mode);

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q_r),
        .op     (step_op),
        .d      (d),
        .sil    (sil),
        .sir    (sir),
        .next_q (next_q)
    );

    always_comb begin
        state_d = state_r;
        q_d     = q_r;
        op_d    = op_r;
        rem_d   = rem_r;
        case (state_r)
            StIdle: begin
                if (start) begin
                    // q is left untouched on the accepting edge.
                    op_d    = mode_e'(mode);
                    rem_d   = amt;
                    state_d = (amt != '0) ? StRun : StDone;
                end else if (en) begin
                    q_d = next_q;
                end
            end
            StRun: begin
                q_d   = next_q;
                rem_d = rem_r - AMT_W'(1);
                if (rem_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_r <= StIdle;
            q_r     <= '0;
            op_r    <= ModeHold;
            rem_r   <= '0;
        end else begin
            state_r <= state_d;
            q_r     <= q_d;
            op_r    <= op_d;
            rem_r   <= rem_d;
        end
    end

    assign q    = q_r;
    assign so_r = q_r[0];
    assign so_l = q_r[WIDTH-1];
    assign busy = (state_r != StIdle);
    assign done = (state_r == StDone);

endmodule

// File: tb/tb_usr_param.sv
// Self-checking bench for usr_param (WIDTH=8): directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a behavioural model.
module tb_usr_param;

`ifdef USR_ROTATE_EN
    localparam bit RotEn = 1'b1;
`else
    localparam bit RotEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic [2:0] mode = 3'd0;
    logic [7:0] d = 8'h00;
    logic       sir = 1'b0;
    logic       sil = 1'b0;
    logic       start = 1'b0;
    logic [3:0] amt = 4'd0;
    logic [7:0] q;
    logic       so_r, so_l, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    usr_param #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sir   (sir),
        .sil   (sil),
        .start (start),
        .amt   (amt),
        .q     (q),
        .so_r  (so_r),
        .so_l  (so_l),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour of one step, written as plain arithmetic on the 8-bit value.
    function automatic logic [7:0] model(input logic [7:0] cur, input logic [2:0] m,
                                         input logic [7:0] dd, input logic il,
                                         input logic ir);
        logic [15:0] w;
        w = {8'h00, cur};
        case (m)
            3'd1: model = 8'(w >> 1) | (ir ? 8'h80 : 8'h00);
            3'd2: model = 8'(w << 1) | {7'd0, il};
            3'd3: model = dd;
            3'd4: model = RotEn ? 8'((w >> 1) | (w << 7)) : cur;
            3'd5: model = RotEn ? 8'((w << 1) | (w >> 7)) : cur;
            3'd6: model = 8'($signed(cur) >>> 1);
            default: model = cur;
        endcase
    endfunction

    function automatic logic [7:0] model_n(input logic [7:0] cur, input logic [2:0] m,
                                           input int n, input logic [7:0] dd,
                                           input logic il, input logic ir);
        logic [7:0] v;
        v = cur;
        for (int i = 0; i < n; i++) v = model(v, m, dd, il, ir);
        return v;
    endfunction

    // Launch a multi-step op and observe it until busy drops (bounded).
    task automatic run_multi(input logic [2:0] m, input logic [3:0] n, input bit noise,
                             output int bcyc, output int dcnt, output logic [7:0] qd);
        start = 1'b1;
        mode  = m;
        amt   = n;
        en    = 1'b1;  // start must win over en
        @(posedge clk); #1;
        start = 1'b0;
        en    = 1'b0;
        bcyc  = 0;
        dcnt  = 0;
        qd    = 8'h00;
        while (busy && bcyc < 40) begin
            bcyc++;
            if (done) begin
                dcnt++;
                qd = q;
            end
            if (noise) begin
                en    = 1'($urandom);
                start = 1'($urandom);
                mode  = 3'($urandom);
                amt   = 4'($urandom);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        en    = 1'b0;
    endtask

    typedef struct {
        logic [2:0] mode;
        logic       en;
        logic [7:0] d;
        logic       sil;
        logic       sir;
        logic [7:0] exp_q;
    } vec_t;

    vec_t       vecs[14];
    logic [7:0] mq;
    int         bc, dc;
    logic [7:0] qd;

    initial begin
        vecs[0]  = '{3'd3, 1'b1, 8'hA5, 1'b0, 1'b0, 8'hA5};  // LOAD
        vecs[1]  = '{3'd1, 1'b1, 8'h00, 1'b0, 1'b1, 8'hD2};  // SHR sir=1
        vecs[2]  = '{3'd2, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA4};  // SHL sil=0
        vecs[3]  = '{3'd2, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA4};  // en=0 holds
        vecs[4]  = '{3'd0, 1'b1, 8'h5A, 1'b1, 1'b1, 8'hA4};  // HOLD
        vecs[5]  = '{3'd7, 1'b1, 8'h5A, 1'b1, 1'b1, 8'hA4};  // reserved
        vecs[6]  = '{3'd3, 1'b1, 8'h80, 1'b0, 1'b0, 8'h80};  // LOAD
        vecs[7]  = '{3'd6, 1'b1, 8'h00, 1'b0, 1'b0, 8'hC0};  // ASR
        vecs[8]  = '{3'd6, 1'b1, 8'h00, 1'b0, 1'b0, 8'hE0};
        vecs[9]  = '{3'd6, 1'b1, 8'h00, 1'b0, 1'b0, 8'hF0};
        vecs[10] = '{3'd3, 1'b1, 8'h81, 1'b0, 1'b0, 8'h81};  // LOAD
        vecs[11] = '{3'd4, 1'b1, 8'h00, 1'b0, 1'b0, RotEn ? 8'hC0 : 8'h81};  // ROR
        vecs[12] = '{3'd5, 1'b1, 8'h00, 1'b0, 1'b0, 8'h81};  // ROL (back, or unchanged)
        vecs[13] = '{3'd2, 1'b1, 8'h00, 1'b1, 1'b0, 8'h03};  // SHL sil=1

        // Reset state
        #12;
        check("reset_q", q, 8'h00);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_so_r", so_r, 1'b0);
        check("reset_so_l", so_l, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;

        // Directed single steps
        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            en   = vecs[i].en;
            d    = vecs[i].d;
            sil  = vecs[i].sil;
            sir  = vecs[i].sir;
            @(posedge clk); #1;
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_so_r", i), so_r, vecs[i].exp_q[0]);
            check($sformatf("vec%0d_so_l", i), so_l, vecs[i].exp_q[7]);
        end
        en = 1'b0;

        // Multi-step SHL x5 from 0x01 with noise on ignored inputs
        mode = 3'd3; d = 8'h01; en = 1'b1;
        @(posedge clk); #1;
        sil = 1'b0;
        run_multi(3'd2, 4'd5, 1'b1, bc, dc, qd);
        check("shl5_busy_cycles", bc, 6);
        check("shl5_done_pulses", dc, 1);
        check("shl5_q_at_done", qd, 8'h20);
        @(posedge clk); #1;
        check("shl5_q_after", q, 8'h20);
        check("shl5_idle", busy, 1'b0);

        // Rotate multi-step, amt=1
        mode = 3'd3; d = 8'h81; en = 1'b1;
        @(posedge clk); #1;
        run_multi(3'd5, 4'd1, 1'b0, bc, dc, qd);
        check("rol1_busy_cycles", bc, 2);
        check("rol1_done_pulses", dc, 1);
        check("rol1_q_at_done", qd, RotEn ? 8'h03 : 8'h81);

        // amt=0: one busy+done cycle, q untouched, en ignored at start edge
        mq = q;
        mode = 3'd2;
        run_multi(3'd2, 4'd0, 1'b0, bc, dc, qd);
        check("amt0_busy_cycles", bc, 1);
        check("amt0_done_pulses", dc, 1);
        check("amt0_q", q, mq);

        // start held high: ignored at the DONE->IDLE edge, accepted next
        start = 1'b1; mode = 3'd0; amt = 4'd0;
        @(posedge clk); #1;
        check("b2b_done1", done, 1'b1);
        @(posedge clk); #1;
        check("b2b_idle_gap", busy, 1'b0);
        @(posedge clk); #1;
        check("b2b_done2", done, 1'b1);
        start = 1'b0;
        @(posedge clk); #1;

        // Reset mid-RUN
        mq = q;
        mode = 3'd1; sir = 1'b1; amt = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_run_busy", busy, 1'b1);
        check("rst_run_q", q, model_n(mq, 3'd1, 2, 8'h00, 1'b0, 1'b1));
        #2 clear = 1'b0;
        #1;
        check("rst_mid_q", q, 8'h00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_after_q", q, 8'h00);
        check("rst_after_busy", busy, 1'b0);

        // Randomized transactions against the model
        mq = q;
        for (int t = 0; t < 60; t++) begin
            d   = 8'($urandom);
            sil = 1'($urandom);
            sir = 1'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                logic [2:0] m;
                logic [3:0] n;
                m = 3'($urandom);
                n = 4'($urandom_range(0, 8));
                run_multi(m, n, 1'b0, bc, dc, qd);
                mq = model_n(mq, m, int'(n), d, sil, sir);
                check($sformatf("rnd%0d_busy_cycles", t), bc, int'(n) + 1);
                check($sformatf("rnd%0d_done_pulses", t), dc, 1);
                check($sformatf("rnd%0d_multi_q", t), q, mq);
            end else begin
                mode = 3'($urandom);
                en   = 1'($urandom);
                @(posedge clk); #1;
                if (en) mq = model(mq, mode, d, sil, sir);
                en = 1'b0;
                check($sformatf("rnd%0d_single_q", t), q, mq);
                check($sformatf("rnd%0d_so_r", t), so_r, mq[0]);
                check($sformatf("rnd%0d_so_l", t), so_l, mq[7]);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
